// File: rtl/clock_set_ctrl_pkg.sv
// Shared types and constants for the DE2 clock time-setting controller.
package clock_set_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2,
    SET_S = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    KEY_NONE  = 2'b00,
    KEY_SHORT = 2'b01,
    KEY_LONG  = 2'b10
  } key_code_e;

  localparam logic [4:0] HOUR_MAX   = 5'd23;
  localparam logic [5:0] MINSEC_MAX = 6'd59;

  function automatic logic [5:0] minsec_inc(input logic [5:0] v);
    return (v >= MINSEC_MAX) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [4:0] hour_inc(input logic [4:0] v);
    return (v >= HOUR_MAX) ? 5'd0 : v + 5'd1;
  endfunction

endpackage

// File: rtl/clock_set_ctrl_key_event_detect.sv
// Turns a sticky classifier press code into one-cycle short/long press pulses.
module clock_set_ctrl_key_event_detect
  import clock_set_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] code,
  output logic       short_evt,
  output logic       long_evt
);

  logic [1:0] prev_q, prev_d;
  logic       short_q, short_d;
  logic       long_q, long_d;

  // A press is only new when the code leaves 00; held or 01<->10 codes never fire.
  always_comb begin
    prev_d  = code;
    short_d = (prev_q == KEY_NONE) && (code == KEY_SHORT);
    long_d  = (prev_q == KEY_NONE) && (code == KEY_LONG);
  end

  // Previous-code and pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q  <= 2'b00;
      short_q <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      short_q <= short_d;
      long_q  <= long_d;
    end
  end

  assign short_evt = short_q;
  assign long_evt  = long_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-setting controller: set-mode sequencing, shadow time editing, load strobe,
// edit timeout and blink mask for the selected field.
module clock_set_ctrl
  import clock_set_ctrl_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int BLINK_HZ  = 2,
  parameter int TIMEOUT_S = 30
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [1:0] mode_state,
  input  logic [1:0] adj_state,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  output logic [4:0] set_hour,
  output logic [5:0] set_min,
  output logic [5:0] set_sec,
  output logic       load,
  output logic       setting,
  output logic [2:0] blink_mask
);

  localparam longint         TO_CYCLES   = longint'(TIMEOUT_S) * longint'(CLK_HZ);
  localparam logic [30:0]    TO_LAST     = 31'(TO_CYCLES - 64'sd1);
  localparam int             HALF_PERIOD = CLK_HZ / (2 * BLINK_HZ);
  localparam int             DIV_W       = $clog2(HALF_PERIOD) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(HALF_PERIOD - 1);
  localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);

  logic mode_short, mode_long, adj_short, adj_long;

  state_e           state_q, state_d;
  logic [4:0]       set_hour_q, set_hour_d;
  logic [5:0]       set_min_q, set_min_d;
  logic [5:0]       set_sec_q, set_sec_d;
  logic             load_q, load_d;
  logic             setting_q, setting_d;
  logic [2:0]       mask_q, mask_d;
  logic [30:0]      to_cnt_q, to_cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             phase_q, phase_d;

  clock_set_ctrl_key_event_detect u_mode_evt (
    .clk       (CLOCK_50),
    .reset     (reset),
    .code      (mode_state),
    .short_evt (mode_short),
    .long_evt  (mode_long)
  );

  clock_set_ctrl_key_event_detect u_adj_evt (
    .clk       (CLOCK_50),
    .reset     (reset),
    .code      (adj_state),
    .short_evt (adj_short),
    .long_evt  (adj_long)
  );

  // Mode FSM, field edits and timeout; mode events shadow adj events in the same cycle.
  always_comb begin
    state_d    = state_q;
    set_hour_d = set_hour_q;
    set_min_d  = set_min_q;
    set_sec_d  = set_sec_q;
    load_d     = 1'b0;
    to_cnt_d   = 31'd0;
    case (state_q)
      RUN: begin
        if (mode_long) begin
          state_d    = SET_H;
          set_hour_d = cur_hour;
          set_min_d  = cur_min;
          set_sec_d  = cur_sec;
        end else begin
          state_d = RUN;
        end
      end
      SET_H, SET_M, SET_S: begin
        if (mode_long) begin
          state_d = RUN;
          load_d  = 1'b1;
        end else if (mode_short) begin
          case (state_q)
            SET_H:   state_d = SET_M;
            SET_M:   state_d = SET_S;
            default: state_d = SET_H;
          endcase
        end else if (adj_short) begin
          case (state_q)
            SET_H:   set_hour_d = hour_inc(set_hour_q);
            SET_M:   set_min_d  = minsec_inc(set_min_q);
            default: set_sec_d  = minsec_inc(set_sec_q);
          endcase
        end else if (adj_long) begin
          case (state_q)
            SET_H:   set_hour_d = 5'd0;
            SET_M:   set_min_d  = 6'd0;
            default: set_sec_d  = 6'd0;
          endcase
        end else if (to_cnt_q == TO_LAST) begin
          state_d = RUN;
        end else begin
          to_cnt_d = to_cnt_q + 31'd1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Blink phase restarts at 0 on every state change so a newly selected field shows first.
  always_comb begin
    div_d   = div_q;
    phase_d = phase_q;
    if (state_d != state_q) begin
      div_d   = '0;
      phase_d = 1'b0;
    end else if (div_q == DIV_LAST) begin
      div_d   = '0;
      phase_d = ~phase_q;
    end else begin
      div_d = div_q + DIV_ONE;
    end
  end

  // Output decode from the next state so the registered outputs line up with state_q.
  always_comb begin
    setting_d = (state_d != RUN);
    case (state_d)
      SET_H:   mask_d = {phase_d, 2'b00};
      SET_M:   mask_d = {1'b0, phase_d, 1'b0};
      SET_S:   mask_d = {2'b00, phase_d};
      default: mask_d = 3'b000;
    endcase
  end

  // State, shadow time, counters and registered outputs.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q    <= RUN;
      set_hour_q <= 5'd0;
      set_min_q  <= 6'd0;
      set_sec_q  <= 6'd0;
      load_q     <= 1'b0;
      setting_q  <= 1'b0;
      mask_q     <= 3'b000;
      to_cnt_q   <= 31'd0;
      div_q      <= '0;
      phase_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      set_hour_q <= set_hour_d;
      set_min_q  <= set_min_d;
      set_sec_q  <= set_sec_d;
      load_q     <= load_d;
      setting_q  <= setting_d;
      mask_q     <= mask_d;
      to_cnt_q   <= to_cnt_d;
      div_q      <= div_d;
      phase_q    <= phase_d;
    end
  end

  assign set_hour   = set_hour_q;
  assign set_min    = set_min_q;
  assign set_sec    = set_sec_q;
  assign load       = load_q;
  assign setting    = setting_q;
  assign blink_mask = mask_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl: directed scenarios plus randomized key traffic
// compared every cycle against a behavioural model of the set-mode rules.
module tb_clock_set_ctrl;

  localparam int CLK_HZ    = 1000;
  localparam int BLINK_HZ  = 2;
  localparam int TIMEOUT_S = 1;
  localparam int TO_CYC    = TIMEOUT_S * CLK_HZ;
  localparam int HALF      = CLK_HZ / (2 * BLINK_HZ);

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] mode_state = 2'b00;
  logic [1:0] adj_state = 2'b00;
  logic [4:0] cur_hour = 5'd0;
  logic [5:0] cur_min = 6'd0;
  logic [5:0] cur_sec = 6'd0;
  logic [4:0] set_hour;
  logic [5:0] set_min, set_sec;
  logic       load, setting;
  logic [2:0] blink_mask;

  int tests = 0;
  int fails = 0;

  clock_set_ctrl #(.CLK_HZ(CLK_HZ), .BLINK_HZ(BLINK_HZ), .TIMEOUT_S(TIMEOUT_S)) dut (
    .CLOCK_50   (clk),
    .reset      (reset),
    .mode_state (mode_state),
    .adj_state  (adj_state),
    .cur_hour   (cur_hour),
    .cur_min    (cur_min),
    .cur_sec    (cur_sec),
    .set_hour   (set_hour),
    .set_min    (set_min),
    .set_sec    (set_sec),
    .load       (load),
    .setting    (setting),
    .blink_mask (blink_mask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      if (fails <= 40) $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: field 0 = running, 1/2/3 = editing hour/min/sec.
  int m_field = 0, m_h = 0, m_m = 0, m_s = 0, m_idle = 0, m_age = 0;
  bit m_load = 1'b0, m_valid = 1'b0;
  logic [1:0] m_prev_mode = 2'b00, m_prev_adj = 2'b00;
  bit p_ms = 1'b0, p_ml = 1'b0, p_as = 1'b0, p_al = 1'b0;

  // A key press is recognised one edge after the code leaves 00 and acts on the following edge.
  always @(posedge clk) begin
    bit ms, ml, as_, al;
    int old_field;
    if (reset) begin
      m_field = 0; m_h = 0; m_m = 0; m_s = 0; m_idle = 0; m_age = 0; m_load = 1'b0;
      m_prev_mode = 2'b00; m_prev_adj = 2'b00;
      p_ms = 1'b0; p_ml = 1'b0; p_as = 1'b0; p_al = 1'b0;
    end else begin
      ms = p_ms; ml = p_ml; as_ = p_as; al = p_al;
      p_ms = (m_prev_mode == 2'b00) && (mode_state == 2'b01);
      p_ml = (m_prev_mode == 2'b00) && (mode_state == 2'b10);
      p_as = (m_prev_adj == 2'b00) && (adj_state == 2'b01);
      p_al = (m_prev_adj == 2'b00) && (adj_state == 2'b10);
      m_prev_mode = mode_state;
      m_prev_adj  = adj_state;
      old_field = m_field;
      m_load = 1'b0;
      if (m_field == 0) begin
        m_idle = 0;
        if (ml) begin
          m_field = 1; m_h = int'(cur_hour); m_m = int'(cur_min); m_s = int'(cur_sec);
        end
      end else if (ml || ms || as_ || al) begin
        m_idle = 0;
        if (ml) begin
          m_load = 1'b1; m_field = 0;
        end else if (ms) begin
          m_field = (m_field % 3) + 1;
        end else if (as_) begin
          if (m_field == 1) m_h = (m_h + 1) % 24;
          else if (m_field == 2) m_m = (m_m + 1) % 60;
          else m_s = (m_s + 1) % 60;
        end else begin
          if (m_field == 1) m_h = 0;
          else if (m_field == 2) m_m = 0;
          else m_s = 0;
        end
      end else begin
        m_idle++;
        if (m_idle == TO_CYC) m_field = 0;
      end
      if (m_field != old_field) m_age = 0;
      else m_age++;
    end
    m_valid = 1'b1;
  end

  // Compare every output against the model on the falling edge.
  always @(negedge clk) begin
    int em;
    if (m_valid) begin
      em = 0;
      if (m_field != 0 && ((m_age / HALF) % 2) == 1) em = 4 >> (m_field - 1);
      chk("set_hour", int'(set_hour), m_h);
      chk("set_min", int'(set_min), m_m);
      chk("set_sec", int'(set_sec), m_s);
      chk("load", int'(load), int'(m_load));
      chk("setting", int'(setting), (m_field != 0) ? 1 : 0);
      chk("blink_mask", int'(blink_mask), em);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    int loads, zeros, ones, hold;
    @(negedge clk);
    step(3);
    chk("rst_setting", int'(setting), 0);
    chk("rst_mask", int'(blink_mask), 0);
    chk("rst_load", int'(load), 0);
    chk("rst_hour", int'(set_hour), 0);
    reset = 1'b0;
    step(2);

    // Entry captures the live time, commit strobes load once.
    cur_hour = 5'd12; cur_min = 6'd34; cur_sec = 6'd56;
    mode_state = 2'b10;
    step(2);
    chk("entry_setting", int'(setting), 1);
    chk("entry_hour", int'(set_hour), 12);
    chk("entry_min", int'(set_min), 34);
    chk("entry_sec", int'(set_sec), 56);
    chk("entry_mask", int'(blink_mask), 0);
    mode_state = 2'b00; step(1);
    mode_state = 2'b10;
    loads = 0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      if (load) begin
        loads++;
        chk("commit_hour", int'(set_hour), 12);
        chk("commit_sec", int'(set_sec), 56);
      end
    end
    chk("commit_loads", loads, 1);
    chk("commit_setting", int'(setting), 0);

    // Field wrap on hour and minute.
    cur_hour = 5'd23; cur_min = 6'd59; cur_sec = 6'd7;
    mode_state = 2'b00; step(1); mode_state = 2'b10; step(2);
    adj_state = 2'b01; step(2);
    chk("wrap_hour", int'(set_hour), 0);
    mode_state = 2'b00; step(1); mode_state = 2'b01; step(2);
    chk("setm_min", int'(set_min), 59);
    adj_state = 2'b00; step(1); adj_state = 2'b01; step(2);
    chk("wrap_min", int'(set_min), 0);
    chk("wrap_sec", int'(set_sec), 7);

    // Held code gives one increment; 01->10 directly is no event.
    adj_state = 2'b00; step(1); adj_state = 2'b01; step(900);
    chk("held_min", int'(set_min), 1);
    adj_state = 2'b10; step(3);
    chk("direct_long_min", int'(set_min), 1);

    // Back to SET_H, then simultaneous mode/adj short.
    mode_state = 2'b00; step(1); mode_state = 2'b01; step(2);
    mode_state = 2'b00; step(1); mode_state = 2'b01; step(2);
    mode_state = 2'b00; adj_state = 2'b00; step(1);
    mode_state = 2'b01; adj_state = 2'b01; step(2);
    chk("simul_hour", int'(set_hour), 0);
    adj_state = 2'b00; step(1); adj_state = 2'b01; step(2);
    chk("simul_then_min", int'(set_min), 2);
    chk("simul_hour_kept", int'(set_hour), 0);

    // Timeout abandons the edit without load.
    loads = 0;
    for (int i = 0; i < 1100; i++) begin
      step(1);
      if (load) loads++;
    end
    chk("timeout_loads", loads, 0);
    chk("timeout_setting", int'(setting), 0);

    // Blink on the minute field.
    mode_state = 2'b00; step(1); mode_state = 2'b10; step(2);
    mode_state = 2'b00; step(1); mode_state = 2'b01; step(2);
    zeros = 0; ones = 0;
    for (int i = 0; i < HALF; i++) begin
      if (blink_mask == 3'b000) zeros++;
      step(1);
    end
    for (int i = 0; i < HALF; i++) begin
      if (blink_mask == 3'b010) ones++;
      step(1);
    end
    chk("blink_shown", zeros, 250);
    chk("blink_blank", ones, 250);

    // Reset mid-edit.
    reset = 1'b1; step(1);
    chk("midrst_setting", int'(setting), 0);
    chk("midrst_hour", int'(set_hour), 0);
    chk("midrst_mask", int'(blink_mask), 0);
    chk("midrst_load", int'(load), 0);
    reset = 1'b0; mode_state = 2'b00; adj_state = 2'b00; step(1);

    // Randomized key traffic.
    for (int c = 0; c < 300; c++) begin
      cur_hour = 5'($urandom_range(0, 23));
      cur_min  = 6'($urandom_range(0, 59));
      cur_sec  = 6'($urandom_range(0, 59));
      if ($urandom_range(0, 19) == 0) begin
        mode_state = 2'b00; adj_state = 2'b00; step(1100);
      end else begin
        mode_state = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 2));
        adj_state  = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 2));
        reset = ($urandom_range(0, 60) == 0);
        hold = reset ? 1 : int'($urandom_range(1, 30));
        step(hold);
        reset = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
